// File: rtl/sprite_loader_pkg.sv
// rtl/sprite_loader_pkg.sv - shared sprite types, loader FSM states and geometry helper
package sprite_loader_pkg;

  localparam int PAT_W    = 32;
  localparam int MAX_COLS = 3;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [9:0] tile;
    logic [1:0] w;
    logic [1:0] h;
    logic [3:0] palette;
    logic       fg_prio;
    logic       bg_prio;
    logic       x_mirror;
    logic       y_mirror;
  } sprite_oam_t;

  typedef struct packed {
    logic [8:0] x;
    logic [1:0] w;
    logic [3:0] palette;
    logic       fg_prio;
    logic       bg_prio;
    logic       x_mirror;
  } sprite_conf_t;

  typedef struct packed {
    sprite_conf_t                 conf;
    logic [MAX_COLS*PAT_W-1:0]    pat;
  } sprite_reg_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SCAN_RD,
    S_SCAN_CHK,
    S_FETCH,
    S_SEND
  } load_state_t;

  // Sprite height in pixel rows: h counts 8-row tiles.
  function automatic logic [4:0] sprite_span(input logic [1:0] h);
    return {h, 3'd0};
  endfunction

endpackage

// File: rtl/sprite_hit_check.sv
// rtl/sprite_hit_check.sv - combinational row hit test and pattern row selection for one OAM entry
module sprite_hit_check
  import sprite_loader_pkg::*;
(
  input  logic [7:0]  row_i,
  input  sprite_oam_t oam_i,
  output logic        hit_o,
  output logic [4:0]  prow_o
);

  logic [7:0] d;
  logic [4:0] span;

  // Modular distance lets sprites near the bottom wrap onto the top rows.
  always_comb begin
    d      = row_i - oam_i.y;
    span   = sprite_span(oam_i.h);
    hit_o  = (oam_i.w != 2'd0) && (oam_i.h != 2'd0) && (d < {3'd0, span});
    prow_o = oam_i.y_mirror ? (span - 5'd1 - d[4:0]) : d[4:0];
  end

endmodule

// File: rtl/sprite_loader.sv
// rtl/sprite_loader.sv - per-scanline OAM scan, pattern fetch and hand-off to the sprite unit chain
module sprite_loader
  import sprite_loader_pkg::*;
#(
  parameter int NUM_SPRITES  = 64,
  parameter int MAX_PER_LINE = 16,
  localparam int IDX_W       = $clog2(NUM_SPRITES),
  localparam int SENT_W      = $clog2(MAX_PER_LINE + 1)
) (
  input  logic              clock,
  input  logic              reset_l,
  input  logic              start_i,
  input  logic [7:0]        row_i,
  output logic [IDX_W-1:0]  oam_addr_o,
  input  sprite_oam_t       oam_rdata_i,
  output logic [12:0]       pat_addr_o,
  input  logic [PAT_W-1:0]  pat_rdata_i,
  output logic              clear_o,
  output sprite_reg_t       out_o,
  output logic              out_valid_o,
  input  logic              out_ack_i,
  output logic              done_o,
  output logic              overflow_o
);

  load_state_t       state_q, state_d;
  logic [7:0]        row_q, row_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SENT_W-1:0] sent_q, sent_d;
  logic [1:0]        c_q, c_d;
  logic [9:0]        tile_q, tile_d;
  logic [4:0]        prow_q, prow_d;
  sprite_reg_t       out_q, out_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;

  logic              hit;
  logic [4:0]        prow;
  logic              last_idx;
  logic [9:0]        tile_idx;

  sprite_hit_check u_hit (
    .row_i  (row_q),
    .oam_i  (oam_rdata_i),
    .hit_o  (hit),
    .prow_o (prow)
  );

  assign last_idx    = (idx_q == IDX_W'(NUM_SPRITES - 1));
  assign tile_idx    = tile_q + {3'd0, prow_q[4:3], 5'd0} + {8'd0, c_q};
  assign pat_addr_o  = {tile_idx, prow_q[2:0]};
  assign oam_addr_o  = idx_q;
  assign clear_o     = (state_q == S_CLR);
  assign out_valid_o = (state_q == S_SEND);
  assign out_o       = out_q;
  assign done_o      = done_q;
  assign overflow_o  = overflow_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    idx_d      = idx_q;
    sent_d     = sent_q;
    c_d        = c_q;
    tile_d     = tile_q;
    prow_d     = prow_q;
    out_d      = out_q;
    done_d     = done_q;
    overflow_d = overflow_q;

    if (start_i) begin
      state_d    = S_CLR;
      row_d      = row_i;
      idx_d      = '0;
      sent_d     = '0;
      overflow_d = 1'b0;
      done_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_CLR:     state_d = S_SCAN_RD;
        S_SCAN_RD: state_d = S_SCAN_CHK;
        S_SCAN_CHK: begin
          if (!hit) begin
            if (last_idx) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_SCAN_RD;
            end
          end else if (sent_q == SENT_W'(MAX_PER_LINE)) begin
            overflow_d = 1'b1;
            done_d     = 1'b1;
            state_d    = S_IDLE;
          end else begin
            tile_d                = oam_rdata_i.tile;
            prow_d                = prow;
            c_d                   = 2'd0;
            out_d                 = '0;
            out_d.conf.x          = oam_rdata_i.x;
            out_d.conf.w          = oam_rdata_i.w;
            out_d.conf.palette    = oam_rdata_i.palette;
            out_d.conf.fg_prio    = oam_rdata_i.fg_prio;
            out_d.conf.bg_prio    = oam_rdata_i.bg_prio;
            out_d.conf.x_mirror   = oam_rdata_i.x_mirror;
            state_d               = S_FETCH;
          end
        end
        S_FETCH: begin
          // Read data trails the address by one cycle, so column c-1 lands while c is issued.
          for (int k = 0; k < MAX_COLS; k++) begin
            if (c_q == 2'(k + 1)) out_d.pat[k*PAT_W +: PAT_W] = pat_rdata_i;
          end
          if (c_q == out_q.conf.w) state_d = S_SEND;
          else                     c_d     = c_q + 2'd1;
        end
        S_SEND: begin
          if (out_ack_i) begin
            sent_d = sent_q + 1'b1;
            if (last_idx) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_SCAN_RD;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      idx_q      <= '0;
      sent_q     <= '0;
      c_q        <= '0;
      tile_q     <= '0;
      prow_q     <= '0;
      out_q      <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      idx_q      <= idx_d;
      sent_q     <= sent_d;
      c_q        <= c_d;
      tile_q     <= tile_d;
      prow_q     <= prow_d;
      out_q      <= out_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
// tb/tb_sprite_loader.sv - self-checking bench for sprite_loader with OAM/pattern memory models
module tb_sprite_loader;
  import sprite_loader_pkg::*;

  logic        clock = 1'b0;
  logic        reset_l = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  row_i = 8'd0;
  logic [5:0]  oam_addr;
  sprite_oam_t oam_rdata = '0;
  logic [12:0] pat_addr;
  logic [31:0] pat_rdata = '0;
  logic        clear;
  sprite_reg_t out;
  logic        out_valid;
  logic        out_ack;
  logic        done;
  logic        overflow;

  int          ack_mode = 0;
  logic        ack_man = 1'b0;
  logic        ack_rnd = 1'b0;

  sprite_oam_t oam_mem [64];
  sprite_reg_t got_q [$];
  sprite_reg_t exp_q [$];
  bit          exp_ovf;
  int          n_checks = 0;
  int          n_pass = 0;

  typedef struct {
    logic [7:0]  y;
    logic [1:0]  h;
    logic [1:0]  w;
    logic [9:0]  tile;
    logic        ymir;
    logic [7:0]  row;
    int          exp_hits;
    logic [12:0] exp_addr0;
  } vec_t;

  sprite_loader #(.NUM_SPRITES(64), .MAX_PER_LINE(16)) dut (
    .clock       (clock),
    .reset_l     (reset_l),
    .start_i     (start_i),
    .row_i       (row_i),
    .oam_addr_o  (oam_addr),
    .oam_rdata_i (oam_rdata),
    .pat_addr_o  (pat_addr),
    .pat_rdata_i (pat_rdata),
    .clear_o     (clear),
    .out_o       (out),
    .out_valid_o (out_valid),
    .out_ack_i   (out_ack),
    .done_o      (done),
    .overflow_o  (overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] pat_word(input logic [12:0] a);
    return {a[7:0], ~a[12:5], a ^ 13'h1abc, 3'b101};
  endfunction

  always @(posedge clock) begin
    oam_rdata <= oam_mem[oam_addr];
    pat_rdata <= pat_word(pat_addr);
  end

  assign out_ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? ack_rnd : ack_man;

  always @(posedge clock) begin
    #1;
    ack_rnd = 1'($urandom);
  end

  always @(negedge clock) begin
    if (reset_l && out_valid && out_ack) got_q.push_back(out);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 64; i++) oam_mem[i] = '0;
  endtask

  // Reference: walk OAM in index order, apply the hit rule, build each expected sprite.
  task automatic model_line(input logic [7:0] r);
    sprite_oam_t e;
    sprite_reg_t s;
    int d, span, prow, t;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < 64; i++) begin
      e = oam_mem[i];
      d = (int'(r) - int'(e.y) + 256) % 256;
      span = int'(e.h) * 8;
      if (e.w != 0 && e.h != 0 && d < span) begin
        if (exp_q.size() == 16) begin
          exp_ovf = 1'b1;
          break;
        end
        prow = e.y_mirror ? (span - 1 - d) : d;
        s = '0;
        s.conf.x = e.x;
        s.conf.w = e.w;
        s.conf.palette = e.palette;
        s.conf.fg_prio = e.fg_prio;
        s.conf.bg_prio = e.bg_prio;
        s.conf.x_mirror = e.x_mirror;
        for (int c = 0; c < int'(e.w); c++) begin
          t = (int'(e.tile) + (prow / 8) * 32 + c) % 1024;
          s.pat[32*c +: 32] = pat_word(13'(t * 8 + prow % 8));
        end
        exp_q.push_back(s);
      end
    end
  endtask

  task automatic do_start(input logic [7:0] r);
    @(posedge clock); #1;
    start_i = 1'b1;
    row_i = r;
    @(posedge clock); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 128'(ok), 128'd1);
  endtask

  task automatic cmp_line(input string tag, input int base);
    int n = got_q.size() - base;
    chk({tag, "_count"}, 128'(n), 128'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk({tag, "_item"}, 128'(got_q[base + i]), 128'(exp_q[i]));
    chk({tag, "_overflow"}, 128'(overflow), 128'(exp_ovf));
  endtask

  initial begin
    vec_t        vecs [9];
    sprite_oam_t e;
    sprite_reg_t held;
    bit          stable, reached;
    logic [12:0] pa [8];
    logic        clr [8];
    logic        ov [8];
    logic [63:0] rnd;
    logic [7:0]  r;
    int          base;

    vecs[0] = '{8'd10,  2'd1, 2'd2, 10'd5,    1'b0, 8'd12,  1, 13'd42};
    vecs[1] = '{8'd0,   2'd2, 2'd1, 10'd7,    1'b1, 8'd3,   1, 13'd316};
    vecs[2] = '{8'd250, 2'd1, 2'd1, 10'd0,    1'b0, 8'd2,   0, 13'd0};
    vecs[3] = '{8'd250, 2'd1, 2'd1, 10'd0,    1'b0, 8'd1,   1, 13'd7};
    vecs[4] = '{8'd0,   2'd0, 2'd1, 10'd9,    1'b0, 8'd0,   0, 13'd0};
    vecs[5] = '{8'd0,   2'd3, 2'd0, 10'd9,    1'b0, 8'd0,   0, 13'd0};
    vecs[6] = '{8'd100, 2'd3, 2'd3, 10'd1020, 1'b0, 8'd123, 1, 13'd487};
    vecs[7] = '{8'd100, 2'd3, 2'd3, 10'd1020, 1'b0, 8'd124, 0, 13'd0};
    vecs[8] = '{8'd5,   2'd1, 2'd1, 10'd3,    1'b1, 8'd5,   1, 13'd31};

    clear_oam();
    #2;
    @(negedge clock);
    chk("rst_clear", 128'(clear), 128'd0);
    chk("rst_out", 128'(out), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_overflow", 128'(overflow), 128'd0);
    chk("rst_oam_addr", 128'(oam_addr), 128'd0);
    chk("rst_pat_addr", 128'(pat_addr), 128'd0);
    @(posedge clock); #1;
    reset_l = 1'b1;

    // Single hit with cycle-exact fetch addresses and back-pressure on the hand-off.
    e = '0; e.y = 8'd10; e.h = 2'd1; e.w = 2'd2; e.tile = 10'd5; e.x = 9'd77; e.palette = 4'd9;
    oam_mem[0] = e;
    ack_mode = 2; ack_man = 1'b0;
    base = got_q.size();
    model_line(8'd12);
    do_start(8'd12);
    for (int k = 1; k < 8; k++) begin
      @(negedge clock);
      pa[k] = pat_addr; clr[k] = clear; ov[k] = out_valid;
    end
    chk("single_clear_pulse", 128'(clr[1]), 128'd1);
    chk("single_clear_once", 128'(clr[2]), 128'd0);
    chk("single_pat_addr0", 128'(pa[4]), 128'd42);
    chk("single_pat_addr1", 128'(pa[5]), 128'd50);
    chk("single_valid_late", 128'(ov[6]), 128'd0);
    chk("single_valid", 128'(ov[7]), 128'd1);
    held = out;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (!out_valid || out !== held) stable = 1'b0;
    end
    chk("bp_stable", 128'(stable), 128'd1);
    chk("bp_no_early_xfer", 128'(got_q.size() - base), 128'd0);
    @(posedge clock); #1 ack_man = 1'b1;
    @(posedge clock); #1 ack_man = 1'b0;
    @(negedge clock);
    chk("bp_valid_drop", 128'(out_valid), 128'd0);
    wait_done("single", 400);
    cmp_line("single", base);

    // Table of single-entry lines covering wrap, mirroring, zero size and tile wrap.
    ack_mode = 0;
    for (int v = 0; v < 9; v++) begin
      clear_oam();
      e = '0; e.y = vecs[v].y; e.h = vecs[v].h; e.w = vecs[v].w;
      e.tile = vecs[v].tile; e.y_mirror = vecs[v].ymir;
      oam_mem[0] = e;
      base = got_q.size();
      model_line(vecs[v].row);
      do_start(vecs[v].row);
      wait_done($sformatf("vec%0d", v), 400);
      chk($sformatf("vec%0d_hits", v), 128'(got_q.size() - base), 128'(vecs[v].exp_hits));
      if (vecs[v].exp_hits != 0 && got_q.size() > base)
        chk($sformatf("vec%0d_word0", v), 128'(got_q[base].pat[31:0]), 128'(pat_word(vecs[v].exp_addr0)));
      cmp_line($sformatf("vec%0d", v), base);
    end

    // Twenty hits on one row: only the first sixteen go out, then overflow.
    clear_oam();
    for (int i = 0; i < 20; i++) begin
      e = '0; e.y = 8'd0; e.h = 2'd1; e.w = 2'd1; e.tile = 10'(i);
      oam_mem[i] = e;
    end
    base = got_q.size();
    model_line(8'd0);
    do_start(8'd0);
    wait_done("ovf", 1000);
    chk("ovf_count", 128'(got_q.size() - base), 128'd16);
    for (int i = 0; i < 16 && base + i < got_q.size(); i++)
      chk("ovf_order", 128'(got_q[base + i].pat[31:0]), 128'(pat_word(13'(i * 8))));
    chk("ovf_flag", 128'(overflow), 128'd1);
    cmp_line("ovf", base);

    // Restart while fetching: the old row is abandoned and the scan restarts.
    clear_oam();
    e = '0; e.y = 8'd0;  e.h = 2'd1; e.w = 2'd3; e.tile = 10'd100; oam_mem[0] = e;
    e = '0; e.y = 8'd40; e.h = 2'd1; e.w = 2'd1; e.tile = 10'd200; oam_mem[5] = e;
    base = got_q.size();
    do_start(8'd2);
    @(posedge clock); @(posedge clock); @(posedge clock); #1;
    start_i = 1'b1; row_i = 8'd42;
    @(posedge clock); #1;
    start_i = 1'b0;
    @(negedge clock);
    chk("restart_clear", 128'(clear), 128'd1);
    chk("restart_valid", 128'(out_valid), 128'd0);
    @(negedge clock);
    chk("restart_clear_end", 128'(clear), 128'd0);
    chk("restart_idx0", 128'(oam_addr), 128'd0);
    model_line(8'd42);
    wait_done("restart", 400);
    cmp_line("restart", base);

    // Randomized lines with random acknowledge against the reference.
    ack_mode = 1;
    for (int n = 0; n < 10; n++) begin
      r = 8'($urandom);
      for (int i = 0; i < 64; i++) begin
        rnd = {$urandom, $urandom};
        e = rnd[$bits(sprite_oam_t)-1:0];
        e.y = r - 8'($urandom_range(0, 30));
        oam_mem[i] = e;
      end
      base = got_q.size();
      model_line(r);
      do_start(r);
      wait_done($sformatf("rand%0d", n), 3000);
      cmp_line($sformatf("rand%0d", n), base);
    end

    // Asynchronous reset while a sprite is waiting for acknowledge.
    clear_oam();
    e = '0; e.y = 8'd10; e.h = 2'd1; e.w = 2'd2; e.tile = 10'd5; e.x = 9'd3;
    oam_mem[0] = e;
    ack_mode = 2; ack_man = 1'b0;
    do_start(8'd12);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (out_valid) begin
        reached = 1'b1;
        break;
      end
    end
    chk("rstsend_reached", 128'(reached), 128'd1);
    #1 reset_l = 1'b0;
    #1;
    chk("rstsend_out_valid", 128'(out_valid), 128'd0);
    chk("rstsend_out", 128'(out), 128'd0);
    chk("rstsend_pat_addr", 128'(pat_addr), 128'd0);
    chk("rstsend_flags", 128'({clear, done, overflow}), 128'd0);
    @(posedge clock); #1 reset_l = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
